// File: rtl/apb_mem_bridge_pkg.sv
// Shared types and constants for the APB-to-SRAM-bank bridge.
// State encoding is kept as fixed constants so older netlists keep the same codes.
package apb_mem_bridge_pkg;

   localparam int CNT_W = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      REQ  = ST_REQ,
      WAIT = ST_WAIT,
      DONE = ST_DONE
   } state_e;

   localparam logic RESP_OKAY   = 1'b0;
   localparam logic RESP_SLVERR = 1'b1;

   // Wait-counter preload: cycles to the read-data sample point, or extra write wait states.
   function automatic logic [CNT_W-1:0] cnt_load(input logic is_write, input int rd_lat,
                                                 input int wr_wait);
      return is_write ? CNT_W'(wr_wait) : CNT_W'(rd_lat);
   endfunction

endpackage

// File: rtl/apb_mem_addr_decode.sv
// Combinational decode of an APB byte address into bank one-hot, word address and error flag.
// Optional protection check is compiled in with APB_PROT_CHECK_EN.
module apb_mem_addr_decode
   import apb_mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = 4,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_DEPTH = 1024
) (
   input  logic [ADDR_WIDTH-1:0]         paddr,
   input  logic [2:0]                    pprot,
   output logic [NUM_BANKS-1:0]          bank_onehot,
   output logic [$clog2(BANK_DEPTH)-1:0] word_addr,
   output logic                          err
);

   localparam int SB      = $clog2(STRB_WIDTH);
   localparam int WB      = $clog2(BANK_DEPTH);
   localparam int BB      = $clog2(NUM_BANKS);
   localparam int TOP_BIT = SB + WB + BB;

   logic misaligned;
   logic out_of_range;
   logic prot_err;

   assign misaligned = |paddr[SB-1:0];
   assign word_addr  = paddr[SB +: WB];

   // Sizes are powers of two, so "above the decoded range" is any set bit above it.
   generate
      if (TOP_BIT < ADDR_WIDTH) begin : g_range
         assign out_of_range = |paddr[ADDR_WIDTH-1:TOP_BIT];
      end else begin : g_no_range
         assign out_of_range = 1'b0;
      end
   endgenerate

   generate
      if (NUM_BANKS == 1) begin : g_single
         assign bank_onehot = 1'b1;
      end else begin : g_multi
         for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
            assign bank_onehot[gi] = (paddr[SB+WB +: BB] == BB'(gi));
         end
      end
   endgenerate

`ifdef APB_PROT_CHECK_EN
   // Only privileged, secure accesses may reach the banks.
   logic unused_prot;
   assign prot_err    = ~pprot[0] | pprot[1];
   assign unused_prot = pprot[2];
`else
   logic [2:0] unused_prot;
   assign prot_err    = 1'b0;
   assign unused_prot = pprot;
`endif

   assign err = misaligned | out_of_range | prot_err;

endmodule

// File: rtl/apb_mem_bridge.sv
// APB4 slave in front of NUM_BANKS synchronous SRAM banks with read latency and write wait states.
// Build option: APB_PROT_CHECK_EN (reject unprivileged / non-secure accesses).
module apb_mem_bridge
   import apb_mem_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8,
   parameter int NUM_BANKS  = 4,
   parameter int BANK_DEPTH = 1024,
   parameter int RD_LATENCY = 1,
   parameter int WR_WAIT    = 0
) (
   input  logic                            pclk,
   input  logic                            prst,
   input  logic [ADDR_WIDTH-1:0]           paddr,
   input  logic [2:0]                      pprot,
   input  logic                            psel,
   input  logic                            penable,
   input  logic                            pwrite,
   input  logic [DATA_WIDTH-1:0]           pwdata,
   input  logic [STRB_WIDTH-1:0]           pstrb,
   output logic                            pready,
   output logic [DATA_WIDTH-1:0]           prdata,
   output logic                            pslverr,
   output logic [NUM_BANKS-1:0]            mem_cs,
   output logic                            mem_we,
   output logic [$clog2(BANK_DEPTH)-1:0]   mem_addr,
   output logic [DATA_WIDTH-1:0]           mem_wdata,
   output logic [STRB_WIDTH-1:0]           mem_strb,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_rdata
);

   localparam int   WORD_W       = $clog2(BANK_DEPTH);
   localparam logic WR_ZERO_WAIT = (WR_WAIT == 0);

   state_e                  state_reg;
   logic [CNT_W-1:0]        cnt_reg;
   logic                    err_reg;
   logic                    we_reg;
   logic [NUM_BANKS-1:0]    cs_sel_reg;
   logic [WORD_W-1:0]       mem_addr_reg;
   logic [DATA_WIDTH-1:0]   mem_wdata_reg;
   logic [STRB_WIDTH-1:0]   mem_strb_reg;
   logic [DATA_WIDTH-1:0]   prdata_reg;

   logic [NUM_BANKS-1:0]    dec_onehot;
   logic [WORD_W-1:0]       dec_word;
   logic                    dec_err;

   logic                    setup_phase;
   logic                    access_phase;
   logic                    in_req;
   logic                    wait_last;
   logic [DATA_WIDTH-1:0]   bank_rdata_masked [NUM_BANKS];
   logic [DATA_WIDTH-1:0]   rdata_sel;

   apb_mem_addr_decode #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .NUM_BANKS  (NUM_BANKS),
      .BANK_DEPTH (BANK_DEPTH)
   ) u_decode (
      .paddr       (paddr),
      .pprot       (pprot),
      .bank_onehot (dec_onehot),
      .word_addr   (dec_word),
      .err         (dec_err)
   );

   assign setup_phase  = psel & ~penable;
   assign access_phase = psel & penable;

   // Read data mux driven by the bank latched at setup.
   generate
      for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_rmux
         assign bank_rdata_masked[gi] = cs_sel_reg[gi] ? mem_rdata[gi*DATA_WIDTH +: DATA_WIDTH]
                                                       : '0;
      end
   endgenerate

   always_comb begin
      rdata_sel = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         rdata_sel = rdata_sel | bank_rdata_masked[b];
      end
   end

   assign in_req    = (state_reg == REQ) && access_phase;
   assign wait_last = (state_reg == WAIT) && access_phase && (cnt_reg == CNT_W'(1));

   assign mem_cs    = (in_req && !err_reg) ? cs_sel_reg : '0;
   assign mem_we    = in_req && !err_reg && we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign mem_strb  = mem_strb_reg;
   assign prdata    = prdata_reg;

   // Outputs gated by the live access phase so an aborted transfer never completes.
   assign pready  = (in_req && (err_reg || (we_reg && WR_ZERO_WAIT)))
                  || (wait_last && we_reg)
                  || ((state_reg == DONE) && access_phase);
   assign pslverr = (in_req && err_reg) ? RESP_SLVERR : RESP_OKAY;

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         err_reg       <= 1'b0;
         we_reg        <= 1'b0;
         cs_sel_reg    <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
         mem_strb_reg  <= '0;
         prdata_reg    <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (setup_phase) begin
                  err_reg    <= dec_err;
                  we_reg     <= pwrite;
                  cs_sel_reg <= dec_onehot;
                  if (!dec_err) begin
                     mem_addr_reg  <= dec_word;
                     mem_wdata_reg <= pwdata;
                     mem_strb_reg  <= pstrb;
                  end
                  state_reg <= REQ;
               end
            end
            REQ: begin
               if (!access_phase) begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else if (err_reg || (we_reg && WR_ZERO_WAIT)) begin
                  state_reg <= IDLE;
               end else begin
                  cnt_reg   <= cnt_load(we_reg, RD_LATENCY, WR_WAIT);
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (!access_phase) begin
                  cnt_reg   <= '0;
                  state_reg <= IDLE;
               end else if (cnt_reg == CNT_W'(1)) begin
                  cnt_reg <= '0;
                  if (we_reg) begin
                     state_reg <= IDLE;
                  end else begin
                     prdata_reg <= rdata_sel;
                     state_reg  <= DONE;
                  end
               end else begin
                  cnt_reg <= cnt_reg - CNT_W'(1);
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Self-checking bench: two bridges (default timing and RD_LATENCY=3/WR_WAIT=2) with bench SRAM models.
// Directed vector table, hand sequences for reset/abort, then random traffic against a word-level model.
module tb_apb_mem_bridge;

   logic        pclk = 1'b0;
   logic        prst;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic        psel_v      [2];
   logic        pready_v    [2];
   logic        pslverr_v   [2];
   logic [31:0] prdata_v    [2];
   logic [3:0]  mem_cs_v    [2];
   logic        mem_we_v    [2];
   logic [9:0]  mem_addr_v  [2];
   logic [31:0] mem_wdata_v [2];
   logic [3:0]  mem_strb_v  [2];
   logic [127:0] mem_rdata_v [2];

   int checks = 0;
   int passed = 0;

   logic [31:0] ref_mem [int];
   logic [31:0] last_rd [2];

   typedef struct {
      int          inst;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      bit          exp_err;
      int          exp_lat;
      logic [3:0]  exp_cs;
      logic [9:0]  exp_maddr;
      logic [31:0] exp_rdata;
   } vec_t;

   always #5 pclk = ~pclk;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_dut
         localparam int LAT = (gi == 0) ? 1 : 3;
         localparam int WW  = (gi == 0) ? 0 : 2;

         logic [31:0]  sram [4][1024];
         logic [127:0] pipe [3];

         apb_mem_bridge #(
            .RD_LATENCY (LAT),
            .WR_WAIT    (WW)
         ) u_dut (
            .pclk      (pclk),
            .prst      (prst),
            .paddr     (paddr),
            .pprot     (pprot),
            .psel      (psel_v[gi]),
            .penable   (penable),
            .pwrite    (pwrite),
            .pwdata    (pwdata),
            .pstrb     (pstrb),
            .pready    (pready_v[gi]),
            .prdata    (prdata_v[gi]),
            .pslverr   (pslverr_v[gi]),
            .mem_cs    (mem_cs_v[gi]),
            .mem_we    (mem_we_v[gi]),
            .mem_addr  (mem_addr_v[gi]),
            .mem_wdata (mem_wdata_v[gi]),
            .mem_strb  (mem_strb_v[gi]),
            .mem_rdata (mem_rdata_v[gi])
         );

         initial begin
            for (int b = 0; b < 4; b++)
               for (int w = 0; w < 1024; w++)
                  sram[b][w] = 32'h0;
            for (int s = 0; s < 3; s++) pipe[s] = '0;
         end

         // Bank output carries junk except exactly LAT cycles after a read request.
         always @(posedge pclk) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_cs_v[gi][b] && mem_we_v[gi])
                  for (int k = 0; k < 4; k++)
                     if (mem_strb_v[gi][k])
                        sram[b][mem_addr_v[gi]][8*k +: 8] <= mem_wdata_v[gi][8*k +: 8];
               pipe[0][32*b +: 32] <= (mem_cs_v[gi][b] && !mem_we_v[gi]) ? sram[b][mem_addr_v[gi]]
                                                                          : $urandom;
            end
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
         end

         assign mem_rdata_v[gi] = pipe[LAT-1];
      end
   endgenerate

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic bit model_err(input logic [31:0] addr, input logic [2:0] prot);
      bit e;
      e = (addr[1:0] != 2'b00) || (addr >= 32'h4000);
`ifdef APB_PROT_CHECK_EN
      e = e || !prot[0] || prot[1];
`endif
      return e;
   endfunction

   function automatic int mkey(input int inst, input logic [31:0] addr);
      return inst * 65536 + int'(addr[13:2]);
   endfunction

   function automatic vec_t predict(input vec_t v);
      vec_t r = v;
      int   k = mkey(v.inst, v.addr);
      r.exp_err   = model_err(v.addr, v.prot);
      r.exp_lat   = r.exp_err ? 0 : (v.wr ? ((v.inst == 0) ? 0 : 2) : ((v.inst == 0) ? 2 : 4));
      r.exp_cs    = r.exp_err ? 4'b0 : (4'b0001 << v.addr[13:12]);
      r.exp_maddr = v.addr[11:2];
      if (!v.wr && !r.exp_err) r.exp_rdata = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      else                     r.exp_rdata = last_rd[v.inst];
      return r;
   endfunction

   task automatic model_update(input vec_t v);
      int          k = mkey(v.inst, v.addr);
      logic [31:0] w;
      if (model_err(v.addr, v.prot)) return;
      w = ref_mem.exists(k) ? ref_mem[k] : 32'h0;
      if (v.wr) begin
         for (int b = 0; b < 4; b++)
            if (v.strb[b]) w[8*b +: 8] = v.wdata[8*b +: 8];
         ref_mem[k] = w;
      end else begin
         last_rd[v.inst] = w;
      end
   endtask

   // Entered and left 1 time unit after a rising edge, so back-to-back calls have no idle gap.
   task automatic xfer(input vec_t v, output bit timeout, output int lat, output bit err,
                       output logic [31:0] rdata, output int cs_cnt, output logic [3:0] cs_seen,
                       output logic [9:0] maddr_seen, output logic [3:0] strb_seen,
                       output bit stray_err);
      timeout = 1; lat = -1; err = 0; rdata = '0; cs_cnt = 0;
      cs_seen = '0; maddr_seen = '0; strb_seen = '0; stray_err = 0;
      paddr = v.addr; pwrite = v.wr; pwdata = v.wdata; pstrb = v.strb; pprot = v.prot;
      psel_v[v.inst] = 1'b1; penable = 1'b0;
      @(negedge pclk);
      if (mem_cs_v[v.inst] != 4'b0) cs_cnt++;
      @(posedge pclk); #1 penable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge pclk);
         if (mem_cs_v[v.inst] != 4'b0) begin
            cs_cnt++;
            cs_seen    = mem_cs_v[v.inst];
            maddr_seen = mem_addr_v[v.inst];
            strb_seen  = mem_strb_v[v.inst];
         end
         if (!pready_v[v.inst] && pslverr_v[v.inst]) stray_err = 1;
         if (pready_v[v.inst]) begin
            timeout = 0; lat = c; err = pslverr_v[v.inst]; rdata = prdata_v[v.inst];
            break;
         end
      end
      @(posedge pclk); #1 psel_v[v.inst] = 1'b0; penable = 1'b0;
   endtask

   task automatic apply(input vec_t v, input string tag);
      bit timeout, err, stray;
      int lat, cs_cnt;
      logic [31:0] rdata;
      logic [3:0]  cs_seen, strb_seen;
      logic [9:0]  maddr_seen;
      xfer(v, timeout, lat, err, rdata, cs_cnt, cs_seen, maddr_seen, strb_seen, stray);
      chk({tag, ".timeout"}, 64'(timeout), 64'(0));
      if (!timeout) begin
         chk({tag, ".pslverr"}, 64'(err), 64'(v.exp_err));
         chk({tag, ".latency"}, 64'(lat), 64'(v.exp_lat));
         chk({tag, ".cs_cycles"}, 64'(cs_cnt), 64'(v.exp_err ? 0 : 1));
         chk({tag, ".stray_err"}, 64'(stray), 64'(0));
         if (!v.exp_err) begin
            chk({tag, ".mem_cs"}, 64'(cs_seen), 64'(v.exp_cs));
            chk({tag, ".mem_addr"}, 64'(maddr_seen), 64'(v.exp_maddr));
            if (v.wr) chk({tag, ".mem_strb"}, 64'(strb_seen), 64'(v.strb));
         end
         if (!v.wr) chk({tag, ".prdata"}, 64'(rdata), 64'(v.exp_rdata));
      end
      $display("xfer %s inst=%0d %s addr=%h lat=%0d err=%0d rdata=%h", tag, v.inst,
               v.wr ? "WR" : "RD", v.addr, lat, err, rdata);
      model_update(v);
   endtask

   task automatic check_idle(input int inst, input string tag);
      chk({tag, ".pready"},    64'(pready_v[inst]),    64'(0));
      chk({tag, ".pslverr"},   64'(pslverr_v[inst]),   64'(0));
      chk({tag, ".mem_cs"},    64'(mem_cs_v[inst]),    64'(0));
      chk({tag, ".mem_we"},    64'(mem_we_v[inst]),    64'(0));
      chk({tag, ".mem_addr"},  64'(mem_addr_v[inst]),  64'(0));
      chk({tag, ".mem_wdata"}, 64'(mem_wdata_v[inst]), 64'(0));
      chk({tag, ".mem_strb"},  64'(mem_strb_v[inst]),  64'(0));
      chk({tag, ".prdata"},    64'(prdata_v[inst]),    64'(0));
   endtask

   function automatic vec_t mk(input int inst, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot, input bit e, input int lat,
                               input logic [3:0] cs, input logic [9:0] ma, input logic [31:0] rd);
      vec_t v;
      v.inst = inst; v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb; v.prot = prot;
      v.exp_err = e; v.exp_lat = lat; v.exp_cs = cs; v.exp_maddr = ma; v.exp_rdata = rd;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[$];
      vec_t v;
      int   bad;

      prst = 1'b1; paddr = '0; pprot = 3'b001; penable = 1'b0; pwrite = 1'b0;
      pwdata = '0; pstrb = '0; psel_v[0] = 1'b0; psel_v[1] = 1'b0;
      last_rd[0] = '0; last_rd[1] = '0;
      repeat (3) @(posedge pclk);
      #1;
      check_idle(0, "rst0");
      check_idle(1, "rst1");
      prst = 1'b0;

      tbl.push_back(mk(0, 1, 32'h1004, 32'hDEADBEEF, 4'hF, 3'b001, 0, 0, 4'b0010, 10'd1, 32'h0));
      tbl.push_back(mk(0, 0, 32'h1004, 32'h0, 4'hF, 3'b001, 0, 2, 4'b0010, 10'd1, 32'hDEADBEEF));
`ifdef APB_PROT_CHECK_EN
      tbl.push_back(mk(0, 0, 32'h1004, 32'h0, 4'hF, 3'b000, 1, 0, 4'b0000, 10'd1, 32'hDEADBEEF));
`else
      tbl.push_back(mk(0, 0, 32'h1004, 32'h0, 4'hF, 3'b000, 0, 2, 4'b0010, 10'd1, 32'hDEADBEEF));
`endif
      tbl.push_back(mk(0, 0, 32'h1004, 32'h0, 4'hF, 3'b001, 0, 2, 4'b0010, 10'd1, 32'hDEADBEEF));
      tbl.push_back(mk(0, 0, 32'h4000, 32'h0, 4'hF, 3'b001, 1, 0, 4'b0000, 10'd0, 32'hDEADBEEF));
      tbl.push_back(mk(0, 1, 32'h0002, 32'h12345678, 4'hF, 3'b001, 1, 0, 4'b0000, 10'd0, 32'h0));
      tbl.push_back(mk(0, 1, 32'h2008, 32'h11223344, 4'b0101, 3'b001, 0, 0, 4'b0100, 10'd2, 32'h0));
      tbl.push_back(mk(0, 0, 32'h2008, 32'h0, 4'hF, 3'b001, 0, 2, 4'b0100, 10'd2, 32'h00220044));
      tbl.push_back(mk(0, 1, 32'h3000, 32'hFFFFFFFF, 4'b0000, 3'b001, 0, 0, 4'b1000, 10'd0, 32'h0));
      tbl.push_back(mk(0, 0, 32'h3000, 32'h0, 4'hF, 3'b001, 0, 2, 4'b1000, 10'd0, 32'h0));
      tbl.push_back(mk(1, 1, 32'h000C, 32'hCAFEF00D, 4'hF, 3'b001, 0, 2, 4'b0001, 10'd3, 32'h0));
      tbl.push_back(mk(1, 0, 32'h000C, 32'h0, 4'hF, 3'b001, 0, 4, 4'b0001, 10'd3, 32'hCAFEF00D));
      tbl.push_back(mk(1, 0, 32'h3FFC, 32'h0, 4'hF, 3'b001, 0, 4, 4'b1000, 10'd1023, 32'h0));
      tbl.push_back(mk(1, 0, 32'h4000, 32'h0, 4'hF, 3'b001, 1, 0, 4'b0000, 10'd0, 32'h0));

      foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

      // Reset held three cycles in the middle of a slow read.
      v = mk(1, 1, 32'h1004, 32'h5A5A1234, 4'hF, 3'b001, 0, 0, 4'b0, 10'd0, 32'h0);
      apply(predict(v), "rstseq.wr");
      v = mk(1, 0, 32'h000C, 32'h0, 4'hF, 3'b001, 0, 0, 4'b0, 10'd0, 32'h0);
      apply(predict(v), "rstseq.rd_before");
      paddr = 32'h1004; pwrite = 1'b0; pprot = 3'b001; psel_v[1] = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 prst = 1'b1; psel_v[1] = 1'b0; penable = 1'b0;
      repeat (3) @(posedge pclk);
      #1;
      check_idle(1, "rstseq.held");
      $display("xfer rstseq inst=1 reset held 3 cycles mid-read");
      prst = 1'b0;
      last_rd[1] = '0;
      v = mk(1, 0, 32'h1004, 32'h0, 4'hF, 3'b001, 0, 0, 4'b0, 10'd0, 32'h0);
      apply(predict(v), "rstseq.rd_after");

      // Abort: psel/penable dropped after the access cycle, before pready.
      paddr = 32'h1004; pwrite = 1'b0; pprot = 3'b001; psel_v[0] = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 psel_v[0] = 1'b0; penable = 1'b0;
      bad = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge pclk);
         if (pready_v[0] || mem_cs_v[0] != 4'b0) bad++;
      end
      chk("abort.quiet", 64'(bad), 64'(0));
      $display("xfer abort inst=0 RD addr=00001004 spurious=%0d", bad);
      @(posedge pclk); #1;
      v = mk(0, 0, 32'h1004, 32'h0, 4'hF, 3'b001, 0, 0, 4'b0, 10'd0, 32'h0);
      apply(predict(v), "abort.recover");

      for (int n = 0; n < 80; n++) begin
         int sel;
         v.inst  = $urandom_range(0, 1);
         v.wr    = 1'($urandom_range(0, 1));
         v.addr  = {18'b0, 2'($urandom_range(0, 3)), 10'($urandom_range(0, 7)), 2'b00};
         sel     = $urandom_range(0, 9);
         if (sel == 0)      v.addr[1:0] = 2'($urandom_range(1, 3));
         else if (sel == 1) v.addr = 32'h4000 + 32'($urandom_range(0, 255) * 4);
         else if (sel == 2) v.addr[31] = 1'b1;
         v.wdata = $urandom;
         v.strb  = 4'($urandom_range(0, 15));
         v.prot  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b001;
         apply(predict(v), $sformatf("rnd%0d", n));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge pclk); #1;
         end
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
